// File: rtl/glm_load_if.sv
// rtl/glm_load_if.sv - shared types plus the DMA read and BRAM write interfaces of glm_load
//
// glm_load_pkg        : cache-line address type and DMA control/status/stream structs
// dma_read_interface  : control (start/addr/regs) out, status (idle/active/done) in,
//                       rx_read (rvalid/rdata) in, tx_read (almostfull) out
// fifobram_interface  : we / waddr / wdata write port into one BRAM channel

package glm_load_pkg;
   typedef logic [41:0] t_claddr;

   typedef struct packed {
      logic            start;
      t_claddr         addr;
      logic [6:0][31:0] regs;
   } t_dma_control;

   typedef struct packed {
      logic idle;
      logic active;
      logic done;
   } t_dma_status;

   typedef struct packed {
      logic         rvalid;
      logic [511:0] rdata;
   } t_dma_rx;

   typedef struct packed {
      logic almostfull;
   } t_dma_tx;
endpackage

interface dma_read_interface;
   import glm_load_pkg::*;
   t_dma_control control;
   t_dma_status  status;
   t_dma_rx      rx_read;
   t_dma_tx      tx_read;

   modport to_dma   (output control, output tx_read, input status, input rx_read);
   modport from_dma (input control, input tx_read, output status, output rx_read);
endinterface

interface fifobram_interface #(parameter int AW = 16);
   logic          we;
   logic [AW-1:0] waddr;
   logic [511:0]  wdata;

   modport bram_write (output we, output waddr, output wdata);
   modport bram       (input we, input waddr, input wdata);
endinterface

// File: rtl/glm_load.sv
// rtl/glm_load.sv - loads a block of DRAM lines through the DMA reader into one BRAM channel
//
// Ports:
//   clk, reset        : single clock, synchronous active-high reset
//   op_start, op_done : start pulse (sampled in IDLE) / one-cycle completion pulse
//   regs[7]           : instruction words (offsets, base select, length, channel, BRAM start)
//   in_addr, out_addr : DRAM base addresses selected by regs[3][31]
//   DMA_read          : DMA reader control/status/data
//   MEM_model         : BRAM write port for channel 0
//   MEM_labels        : BRAM write port for channel 1

module glm_load
   import glm_load_pkg::*;
#(
   parameter int NUM_LOAD_CHANNELS = 2,
   parameter int BRAM_ADDR_W       = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 op_start,
   output logic                 op_done,
   input  logic [6:0][31:0]     regs,
   input  t_claddr              in_addr,
   input  t_claddr              out_addr,
   dma_read_interface.to_dma    DMA_read,
   fifobram_interface.bram_write MEM_model,
   fifobram_interface.bram_write MEM_labels
);

   typedef enum logic [2:0] {
      IDLE,
      PREPROCESS,
      TRIGGER,
      READ,
      DONE
   } state_t;

   state_t state, state_n;

   t_claddr                addr;
   logic [2:0][31:0]       off;
   logic [31:0]            len;
   logic [3:0]             ch;
   logic [BRAM_ADDR_W-1:0] start_addr;
   logic [31:0]            recv_count;
   logic [1:0]             pre_idx;

   logic                   ctrl_start;
   logic                   almostfull;
   logic                   done_q;
   logic                   we_model;
   logic                   we_labels;
   logic [BRAM_ADDR_W-1:0] waddr_q;
   logic [511:0]           wdata_q;

   logic                   accept;
   logic                   fire;
   logic [6:0][31:0]       ctrl_regs;

   // Channel and BRAM-start words only carry a few meaningful bits.
   logic unused_regs;
   assign unused_regs = &{1'b0, regs[5][31:4], regs[6][31:BRAM_ADDR_W]};

   assign accept = (state == READ) && DMA_read.status.active && DMA_read.rx_read.rvalid;
   assign fire   = (state == TRIGGER) && DMA_read.status.idle;

   always_comb begin
      state_n = state;
      case (state)
         IDLE: begin
            if (op_start) begin
               state_n = (regs[4] == 32'd0) ? DONE : PREPROCESS;
            end
         end
         PREPROCESS: begin
            if (pre_idx == 2'd2) begin
               state_n = TRIGGER;
            end
         end
         TRIGGER: begin
            if (DMA_read.status.idle) begin
               state_n = READ;
            end
         end
         READ: begin
            // The length-th line and an early DMA done both end the transfer.
            if ((accept && ((recv_count + 32'd1) == len)) || DMA_read.status.done) begin
               state_n = DONE;
            end
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      ctrl_regs    = '0;
      ctrl_regs[4] = len;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         ctrl_start <= 1'b0;
         done_q     <= 1'b0;
         we_model   <= 1'b0;
         we_labels  <= 1'b0;
         almostfull <= 1'b1;
         recv_count <= '0;
         pre_idx    <= '0;
      end else begin
         state      <= state_n;
         ctrl_start <= fire;
         done_q     <= (state == DONE);
         // Registered from the next state so it tracks the state exactly.
         almostfull <= (state_n != READ);
         we_model   <= accept && (ch == 4'd0);
         we_labels  <= accept && (ch == 4'd1) && (NUM_LOAD_CHANNELS > 1);
         if (accept) begin
            waddr_q <= start_addr + recv_count[BRAM_ADDR_W-1:0];
            wdata_q <= DMA_read.rx_read.rdata;
         end
         case (state)
            IDLE: begin
               if (op_start) begin
                  addr       <= (regs[3][31] ? out_addr : in_addr) + {11'b0, regs[3][30:0]};
                  off        <= regs[2:0];
                  len        <= regs[4];
                  ch         <= regs[5][3:0];
                  start_addr <= regs[6][BRAM_ADDR_W-1:0];
                  recv_count <= '0;
                  pre_idx    <= '0;
               end
            end
            PREPROCESS: begin
               addr    <= addr + {10'b0, off[pre_idx]};
               pre_idx <= pre_idx + 2'd1;
            end
            READ: begin
               if (accept) begin
                  recv_count <= recv_count + 32'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign op_done = done_q;

   assign DMA_read.control = '{start: ctrl_start, addr: addr, regs: ctrl_regs};
   assign DMA_read.tx_read = '{almostfull: almostfull};

   assign MEM_model.we     = we_model;
   assign MEM_model.waddr  = waddr_q;
   assign MEM_model.wdata  = wdata_q;
   assign MEM_labels.we    = we_labels;
   assign MEM_labels.waddr = waddr_q;
   assign MEM_labels.wdata = wdata_q;

endmodule
